adsr_voice_sequencer: RTL and testbench

- Per-voice envelope context store and time-multiplexing sequencer around the combinational ADSR next-state stage.
- On each sample tick it sweeps all voices, one per clock:
  - presents the voice's stored state, volume and pending note events to the ADSR stage;
  - writes back the returned state and volume;
  - emits a clamped per-voice volume stream to the downstream mixer.
- Latches asynchronous note-on/note-off requests from the MIDI decoder until the voice's next sweep slot consumes them.

---
 rtl/adsr_voice_sequencer.sv | 145 ++++++++++++++
 tb/tb_adsr_voice_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_voice_sequencer.sv
// Per-voice ADSR context store and sweep sequencer: on each sample tick it walks every voice
// through the shared combinational ADSR stage, writes the result back, and streams clamped volumes.
module adsr_voice_sequencer #(
  parameter int NB_VOICES = 16,
  parameter int VOICE_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               note_on_valid,
  input  logic [VOICE_W-1:0] note_on_voice,
  input  logic               note_off_valid,
  input  logic [VOICE_W-1:0] note_off_voice,
  output logic [2:0]         adsr_i_state,
  output logic [17:0]        adsr_i_volume,
  output logic               adsr_i_pressed,
  output logic               adsr_i_released,
  input  logic [2:0]         adsr_o_state,
  input  logic [17:0]        adsr_o_volume,
  output logic               vol_valid,
  output logic [VOICE_W-1:0] vol_voice,
  output logic [17:0]        vol_data,
  output logic               busy,
  output logic               sweep_done,
  output logic               overrun
);

  // Volume stream: vol_valid is a one-cycle strobe per voice, no backpressure; vol_voice,
  // vol_data and sweep_done are only meaningful while vol_valid is high.
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} seq_state_t;

  seq_state_t         r_state, w_state_nxt;
  logic [VOICE_W-1:0] r_v, w_v_nxt;
  logic [2:0]         r_st  [NB_VOICES];
  logic [17:0]        r_vol [NB_VOICES];
  logic [NB_VOICES-1:0] r_press, r_release;
  logic               r_vol_valid, r_sweep_done, r_overrun;
  logic [VOICE_W-1:0] r_vol_voice;
  logic [17:0]        r_vol_data;
  logic               w_sweep, w_last, w_tick_busy;

  assign w_sweep = (r_state == SWEEP);
  assign w_last  = (r_v == VOICE_W'(NB_VOICES - 1));
  // The sweep_done cycle still counts as busy for incoming ticks.
  assign w_tick_busy = sample_tick && (w_sweep || r_sweep_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    case (r_state)
      IDLE: begin
        if (sample_tick && !r_sweep_done) begin
          w_state_nxt = SWEEP;
          w_v_nxt     = '0;
        end
      end
      SWEEP: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_v_nxt     = '0;
        end else begin
          w_v_nxt = r_v + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    adsr_i_state    = '0;
    adsr_i_volume   = '0;
    adsr_i_pressed  = 1'b0;
    adsr_i_released = 1'b0;
    if (w_sweep) begin
      adsr_i_state    = r_st[r_v];
      adsr_i_volume   = r_vol[r_v];
      adsr_i_pressed  = r_press[r_v];
      adsr_i_released = r_release[r_v];
    end
  end

  // Later assignments win: consume-clear, then note-on, then note-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_VOICES; i++) begin
        r_st[i]  <= '0;
        r_vol[i] <= '0;
      end
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < NB_VOICES; i++) begin
        if (w_sweep && (r_v == VOICE_W'(i))) begin
          r_st[i]      <= adsr_o_state;
          r_vol[i]     <= adsr_o_volume;
          r_press[i]   <= 1'b0;
          r_release[i] <= 1'b0;
        end
        if (note_on_valid && (note_on_voice == VOICE_W'(i))) begin
          r_press[i]   <= 1'b1;
          r_release[i] <= 1'b0;
        end
        if (note_off_valid && (note_off_voice == VOICE_W'(i))) begin
          r_press[i]   <= 1'b0;
          r_release[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vol_valid  <= 1'b0;
      r_vol_voice  <= '0;
      r_vol_data   <= '0;
      r_sweep_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_vol_valid  <= w_sweep;
      r_sweep_done <= w_sweep && w_last;
      r_overrun    <= r_overrun || w_tick_busy;
      if (w_sweep) begin
        r_vol_voice <= r_v;
        r_vol_data  <= adsr_o_volume[17] ? 18'h0 : {1'b0, adsr_o_volume[16:0]};
      end
    end
  end

  assign busy       = w_sweep;
  assign vol_valid  = r_vol_valid;
  assign vol_voice  = r_vol_voice;
  assign vol_data   = r_vol_data;
  assign sweep_done = r_sweep_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_adsr_voice_sequencer.sv
// Bench for adsr_voice_sequencer: plays the ADSR stage with random returns and keeps a per-voice
// reference model; a negedge monitor pops expected ADSR drives and volume beats from queues.
module tb_adsr_voice_sequencer;
  localparam int NB = 16;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          note_on_valid = 1'b0;
  logic [VW-1:0] note_on_voice = '0;
  logic          note_off_valid = 1'b0;
  logic [VW-1:0] note_off_voice = '0;
  logic [2:0]    adsr_i_state;
  logic [17:0]   adsr_i_volume;
  logic          adsr_i_pressed, adsr_i_released;
  logic [2:0]    adsr_o_state = '0;
  logic [17:0]   adsr_o_volume = '0;
  logic          vol_valid;
  logic [VW-1:0] vol_voice;
  logic [17:0]   vol_data;
  logic          busy, sweep_done, overrun;

  adsr_voice_sequencer #(.NB_VOICES(NB), .VOICE_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .note_on_valid(note_on_valid), .note_on_voice(note_on_voice),
    .note_off_valid(note_off_valid), .note_off_voice(note_off_voice),
    .adsr_i_state(adsr_i_state), .adsr_i_volume(adsr_i_volume),
    .adsr_i_pressed(adsr_i_pressed), .adsr_i_released(adsr_i_released),
    .adsr_o_state(adsr_o_state), .adsr_o_volume(adsr_o_volume),
    .vol_valid(vol_valid), .vol_voice(vol_voice), .vol_data(vol_data),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [22:0] exp_q[$];   // {voice, clamped volume, sweep_done}
  logic [22:0] adsr_q[$];  // {state, volume, pressed, released}
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // ---------------- reference model ----------------
  logic [2:0]  m_st [NB];
  logic [17:0] m_vol[NB];
  bit          m_pr [NB];
  bit          m_rl [NB];
  int          m_slot = -1;     // voice processed this cycle, -1 when no sweep
  bit          m_done_cyc = 1'b0;
  bit          m_overrun = 1'b0;
  int          f_voice = -1;    // forced ADSR return for one voice
  logic [17:0] f_val = '0;
  bit          quiet = 1'b0;    // ADSR stage returns BLANK/0

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = '0; m_vol[i] = '0; m_pr[i] = 1'b0; m_rl[i] = 1'b0;
    end
    m_slot = -1; m_done_cyc = 1'b0; m_overrun = 1'b0;
    exp_q.delete(); adsr_q.delete();
  endtask

  // One clock cycle of stimulus; the model predicts what the DUT does in this cycle.
  task automatic step(input bit tick, input bit on_v, input int on_n, input bit off_v, input int off_n);
    logic [2:0]  ret_st;
    logic [17:0] ret_vol;
    bit          next_done;
    @(posedge clk); #1;
    ret_st  = 3'($urandom_range(0, 4));
    ret_vol = 18'($urandom) & 18'h1FFFF;
    if ($urandom_range(0, 3) == 0) ret_vol[17] = 1'b1;
    if (quiet) begin ret_st = '0; ret_vol = '0; end
    if (m_slot >= 0 && m_slot == f_voice) ret_vol = f_val;
    sample_tick    = tick;
    note_on_valid  = on_v;  note_on_voice  = VW'(on_n);
    note_off_valid = off_v; note_off_voice = VW'(off_n);
    adsr_o_state   = ret_st; adsr_o_volume = ret_vol;
    if (m_slot >= 0) begin
      adsr_q.push_back({m_st[m_slot], m_vol[m_slot], m_pr[m_slot], m_rl[m_slot]});
      exp_q.push_back({VW'(m_slot), (ret_vol[17] ? 18'h0 : {1'b0, ret_vol[16:0]}), (m_slot == NB - 1)});
      m_st[m_slot] = ret_st; m_vol[m_slot] = ret_vol;
      m_pr[m_slot] = 1'b0;   m_rl[m_slot] = 1'b0;
    end
    if (on_v && on_n < NB)  begin m_pr[on_n] = 1'b1;  m_rl[on_n] = 1'b0;  end
    if (off_v && off_n < NB) begin m_rl[off_n] = 1'b1; m_pr[off_n] = 1'b0; end
    next_done = (m_slot == NB - 1);
    if (tick && (m_slot >= 0 || m_done_cyc)) m_overrun = 1'b1;
    if (m_slot >= 0) m_slot = (m_slot == NB - 1) ? -1 : m_slot + 1;
    else if (tick && !m_done_cyc) m_slot = 0;
    m_done_cyc = next_done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic sweep();
    step(1, 0, 0, 0, 0);
    idle(NB + 3);
  endtask

  task automatic drain_check(input string name);
    idle(3);
    check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_adsr_left"}, 64'(adsr_q.size()), 64'd0);
    @(negedge clk);
    check({name, "_overrun"}, 64'(overrun), 64'(m_overrun));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0; rst_n = 1'b0;
    sample_tick = 1'b0; note_on_valid = 1'b0; note_off_valid = 1'b0;
    adsr_o_state = '0; adsr_o_volume = '0;
    model_clear();
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vol_valid", 64'(vol_valid), 64'd0);
    check("rst_vol", 64'({vol_voice, vol_data}), 64'd0);
    check("rst_sweep_done", 64'(sweep_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_adsr_i", 64'({adsr_i_state, adsr_i_volume, adsr_i_pressed, adsr_i_released}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [22:0] e;
    if (mon_en && rst_n) begin
      if (busy) begin
        if (adsr_q.size() == 0) check("adsr_unexpected_busy", 64'(busy), 64'd0);
        else begin
          e = adsr_q.pop_front();
          check("adsr_drive", 64'({adsr_i_state, adsr_i_volume, adsr_i_pressed, adsr_i_released}), 64'(e));
        end
      end else begin
        check("adsr_idle_zero", 64'({adsr_i_state, adsr_i_volume, adsr_i_pressed, adsr_i_released}), 64'd0);
      end
      if (vol_valid) begin
        if (exp_q.size() == 0) check("vol_unexpected", 64'(vol_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("vol_beat", 64'({vol_voice, vol_data, sweep_done}), 64'(e));
        end
      end else if (sweep_done) begin
        check("sweep_done_alone", 64'(sweep_done), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    quiet = 1'b1;                           // silent sweep, all zero volumes
    sweep();
    drain_check("quiet");
    quiet = 1'b0;

    step(0, 1, 3, 0, 0);                    // press voice 3
    sweep();
    sweep();
    drain_check("note_on3");

    f_voice = 5; f_val = 18'h3FFF0;         // RELEASE underflow on voice 5
    sweep();
    f_voice = -1;
    sweep();
    drain_check("underflow5");

    step(0, 1, 7, 1, 7);                    // on+off same voice: off wins
    step(0, 1, 9, 1, 11);                   // different voices: both apply
    sweep();
    sweep();
    drain_check("on_off");

    step(1, 0, 0, 0, 0);                    // release voice 2 during its own slot
    idle(2);
    step(0, 0, 0, 1, 2);
    idle(NB + 2);
    sweep();
    drain_check("off_in_slot");

    step(1, 0, 0, 0, 0);                    // tick 4 cycles into a sweep
    idle(3);
    step(1, 0, 0, 0, 0);
    idle(NB + 2);
    drain_check("overrun_mid");
    sweep();
    drain_check("overrun_sticky");

    step(1, 0, 0, 0, 0);                    // reset mid-sweep
    idle(6);
    do_reset();
    idle(NB + 4);
    drain_check("abort");

    step(1, 0, 0, 0, 0);                    // tick in the sweep_done cycle
    idle(NB);
    step(1, 0, 0, 0, 0);
    idle(NB + 3);
    drain_check("tick_on_done");

    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), $urandom_range(0, NB - 1),
           ($urandom_range(0, 3) == 0), $urandom_range(0, NB - 1));
    end
    idle(NB + 2);
    drain_check("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
